// File: rtl/power_debounce_monitor.sv
// Debounce stage for the synchronized power-good level: qualifies level changes
// with a hold count and reports stable level, edge pulses, event counters and a fault flag.
module power_debounce_monitor #(
  parameter int unsigned DEBOUNCE_CNT = 1000,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned EVT_W        = 8
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             pwr_sync_i,
  input  logic             fault_clr_i,
  input  logic             cnt_clr_i,
  output logic             pwr_stable_o,
  output logic             pwr_up_o,
  output logic             pwr_down_o,
  output logic [EVT_W-1:0] glitch_cnt_o,
  output logic [EVT_W-1:0] drop_cnt_o,
  output logic             fault_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    ON_PEND  = 2'd1,
    ON       = 2'd2,
    OFF_PEND = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(DEBOUNCE_CNT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             stable_d;
  logic             up_d, down_d;
  logic             glitch_inc, drop_inc;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    stable_d   = pwr_stable_o;
    up_d       = 1'b0;
    down_d     = 1'b0;
    glitch_inc = 1'b0;
    drop_inc   = 1'b0;
    unique case (state_q)
      OFF: begin
        if (pwr_sync_i) begin
          state_d = ON_PEND;
          hold_d  = CNT_W'(1);
        end
      end
      ON_PEND: begin
        if (!pwr_sync_i) begin
          state_d    = OFF;
          hold_d     = '0;
          glitch_inc = 1'b1;
        end else if (hold_q == HOLD_MAX) begin
          state_d  = ON;
          hold_d   = '0;
          stable_d = 1'b1;
          up_d     = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ON: begin
        if (!pwr_sync_i) begin
          state_d = OFF_PEND;
          hold_d  = CNT_W'(1);
        end
      end
      OFF_PEND: begin
        // Abandoning a pending fall keeps the stable level high and emits no pulse.
        if (pwr_sync_i) begin
          state_d    = ON;
          hold_d     = '0;
          glitch_inc = 1'b1;
        end else if (hold_q == HOLD_MAX) begin
          state_d  = OFF;
          hold_d   = '0;
          stable_d = 1'b0;
          down_d   = 1'b1;
          drop_inc = 1'b1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = OFF;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q      <= OFF;
      hold_q       <= '0;
      pwr_stable_o <= 1'b0;
      pwr_up_o     <= 1'b0;
      pwr_down_o   <= 1'b0;
      glitch_cnt_o <= '0;
      drop_cnt_o   <= '0;
      fault_o      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      pwr_stable_o <= stable_d;
      pwr_up_o     <= up_d;
      pwr_down_o   <= down_d;

      if (cnt_clr_i) begin
        glitch_cnt_o <= '0;
        drop_cnt_o   <= '0;
      end else begin
        if (glitch_inc && (glitch_cnt_o != '1)) glitch_cnt_o <= glitch_cnt_o + 1'b1;
        if (drop_inc && (drop_cnt_o != '1))     drop_cnt_o   <= drop_cnt_o + 1'b1;
      end

      // A new confirmed fall takes priority over a coincident clear.
      if (drop_inc)         fault_o <= 1'b1;
      else if (fault_clr_i) fault_o <= 1'b0;
    end
  end

  assign state_o = state_q;

endmodule
